instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 135 +++++++++++++
 tb/tb_instr_encoder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: packs RV32-style fields into a 32-bit instruction
// word, flags out-of-range or misaligned immediates, and buffers results
// in a 2-entry FIFO with a valid/ready handshake on both sides.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic signed [31:0] imm_s;
  logic [31:0]        enc_instr;
  logic               enc_err;

  logic [31:0] mem_instr [2];
  logic        mem_err   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign imm_s = $signed(in_imm);

  // Pack fields per format and flag range/alignment/format errors.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    enc_instr = NOP;
    enc_err   = 1'b1;
    case (in_fmt)
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = (in_imm[11:0] != 12'h000);
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
      end
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
    if (enc_err) begin
      enc_instr = NOP;
    end
  end

  assign in_ready  = rst_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is masked while empty so outputs read zero after reset.
  assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'h0;
  assign out_err   = out_valid ? mem_err[rd_ptr]   : 1'b0;

  // FIFO storage write on push.
  // NOTE: storage is not reset; emptiness is tracked by count and the outputs are masked, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= enc_instr;
      mem_err[wr_ptr]   <= enc_err;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as 1-bit values.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of error-free accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= 16'h0000;
    end else if (push && !enc_err && (enc_count != 16'hFFFF)) begin
      enc_count <= enc_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed and randomized requests, with a
// scoreboard fed at acceptance and drained by an independent monitor.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    int unsigned fmt, op, rd, rs1, rs2, f3, f7;
    logic [31:0] imm;
  } req_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_count = 0;
  bit   rand_rdy = 0;
  bit   prev_hold = 0;
  logic [31:0] prev_instr;
  logic        prev_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding written from the field rules with shifts and masks.
  function automatic exp_t model(input req_t r);
    exp_t e;
    int s;
    int unsigned u;
    s = int'($signed(r.imm));
    u = r.imm;
    e.err = 1'b0;
    e.instr = 32'h0;
    case (r.fmt)
      0: e.instr = (r.f7 << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12) | (r.rd << 7) | r.op;
      1: begin
        e.err = (s < -2048) || (s > 2047);
        e.instr = ((u & 32'hFFF) << 20) | (r.rs1 << 15) | (r.f3 << 12) | (r.rd << 7) | r.op;
      end
      2: begin
        e.err = (s < -2048) || (s > 2047);
        e.instr = (((u >> 5) & 127) << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12)
                | ((u & 31) << 7) | r.op;
      end
      3: begin
        e.err = (s < -4096) || (s > 4094) || ((u & 1) != 0);
        e.instr = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r.rs2 << 20) | (r.rs1 << 15)
                | (r.f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | r.op;
      end
      4: begin
        e.err = (u % 4096) != 0;
        e.instr = (u & 32'hFFFFF000) | (r.rd << 7) | r.op;
      end
      5: begin
        e.err = (s < -1048576) || (s > 1048574) || ((u & 1) != 0);
        e.instr = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 255) << 12) | (r.rd << 7) | r.op;
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) e.instr = 32'h0000_0013;
    return e;
  endfunction

  function automatic req_t mk(input int unsigned fmt, op, rd, rs1, rs2, f3, f7, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    int edges [14] = '{-2049, -2048, 2047, 2048, -4096, -4098, 4094, 4095, 4096,
                       -1048576, 1048574, 1048575, 1048576, 0};
    req_t r;
    r = mk($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), $urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'($signed($urandom_range(0, 8191)) - 4096);
      2: r.imm = 32'(edges[$urandom_range(0, 13)]);
      default: r.imm = (r.fmt == 4) ? ($urandom & 32'hFFFFF000) : 32'($signed($urandom_range(0, 4095)) - 2048) & ~32'h1;
    endcase
    return r;
  endfunction

  task automatic drive(input req_t r);
    in_fmt = 3'(r.fmt); in_opcode = 7'(r.op); in_rd = 5'(r.rd); in_rs1 = 5'(r.rs1);
    in_rs2 = 5'(r.rs2); in_funct3 = 3'(r.f3); in_funct7 = 7'(r.f7); in_imm = r.imm;
    in_valid = 1'b1;
  endtask

  // Holds the current request until accepted; returns at posedge+1 after acceptance.
  task automatic wait_accept();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: request not accepted within 200 cycles at %0t", $time);
    end
  endtask

  task automatic send(input req_t r);
    drive(r);
    wait_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Scoreboard producer: models each request the DUT is about to accept.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      req_t r;
      exp_t e;
      check("enc_count", 32'(enc_count), 32'(model_count));
      r = mk(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      e = model(r);
      sb.push_back(e);
      if (!e.err && model_count < 65535) model_count++;
    end
  end

  // Monitor: compares the head entry whenever it will pop, and checks hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && out_valid) begin
        check("hold_instr", out_instr, prev_instr);
        check("hold_err", 32'(out_err), 32'(prev_err));
      end
      prev_hold  = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%08h, expected no entry at %0t", out_instr, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_instr", out_instr, e.instr);
          check("out_err", 32'(out_err), 32'(e.err));
        end
      end
    end
  end

  // Reset discards everything the scoreboard was expecting.
  always @(negedge rst_n) begin
    sb.delete();
    model_count = 0;
    prev_hold = 0;
  end

  // Random output backpressure while enabled.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    req_t ra, rb, rc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);

    // Basic I-type accepted on the first edge after reset release.
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(mk(1, 7'h13, 1, 2, 0, 0, 0, 32'hFFFF_FFFF));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("i_out_valid", 32'(out_valid), 32'd1);
    check("i_out_instr", out_instr, 32'hFFF1_0093);
    check("i_out_err", 32'(out_err), 32'd0);
    check("i_enc_count", 32'(enc_count), 32'd1);

    // B and U packing.
    send(mk(3, 7'h63, 0, 1, 2, 0, 0, 32'd8));
    check("b_out_instr", out_instr, 32'h0020_8463);
    send(mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000));
    check("u_out_instr", out_instr, 32'h1234_52B7);

    // Error entries leave enc_count alone.
    send(mk(3, 7'h63, 0, 1, 2, 0, 0, 32'd3));
    check("berr_instr", out_instr, 32'h0000_0013);
    check("berr_err", 32'(out_err), 32'd1);
    send(mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h0010_0000));
    check("jerr_err", 32'(out_err), 32'd1);
    send(mk(7, 7'h13, 1, 0, 0, 0, 0, 32'd0));
    check("fmterr_err", 32'(out_err), 32'd1);
    check("err_enc_count", 32'(enc_count), 32'd3);
    drain();

    // Backpressure: A and B fill the FIFO, C is held off.
    out_ready = 1'b0;
    ra = mk(0, 7'h33, 3, 4, 5, 1, 7'h20, 0);
    rb = mk(2, 7'h23, 0, 6, 7, 2, 0, 32'hFFFF_F800);
    rc = mk(1, 7'h13, 9, 10, 0, 3, 0, 32'd2047);
    send(ra);
    send(rb);
    drive(rc);
    repeat (3) begin
      check("bp_in_ready_full", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Occupancy 1 with push and pop every cycle.
    send(rand_req());
    for (int i = 0; i < 10; i++) begin
      send(mk(1, 7'h13, i, i + 1, 0, 0, 0, 32'(i * 100)));
      check("pp_out_valid", 32'(out_valid), 32'd1);
      check("pp_in_ready", 32'(in_ready), 32'd1);
    end
    drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_req());
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Saturation of enc_count.
    while (model_count < 65535) send(mk(0, 7'h33, 1, 2, 3, 0, 0, 0));
    check("sat_count_max", 32'(enc_count), 32'h0000_FFFF);
    send(mk(1, 7'h13, 1, 2, 0, 0, 0, 32'd5));
    check("sat_count_hold", 32'(enc_count), 32'h0000_FFFF);
    drain();

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(mk(0, 7'h33, 1, 2, 3, 0, 0, 0));
    send(mk(1, 7'h13, 4, 5, 0, 0, 0, 32'd7));
    check("mr_full", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_enc_count", 32'(enc_count), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd0);
    check("mr_out_instr", out_instr, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(mk(4, 7'h17, 8, 0, 0, 0, 0, 32'hABCD_E000));
    check("mr_new_valid", 32'(out_valid), 32'd1);
    check("mr_new_instr", out_instr, 32'hABCD_E417);
    @(posedge clk);
    #1;
    check("mr_single_entry", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mr_alone_empty", 32'(out_valid), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
